// File: rtl/alu_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : alu_sequencer
//  Description : Accumulator-based instruction sequencer that drives an 8-bit
//                combinational ALU (AND/OR/ADD/SUB). Instructions arrive over
//                a valid/ready handshake; OUT emits the accumulator over a
//                second valid/ready handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_sequencer #(
    parameter int DATA_W     = 8,
    parameter int REG_ADDR_W = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  instr_valid,
    output logic                  instr_ready,
    input  logic [2:0]            instr_op,
    input  logic                  instr_src,
    input  logic [REG_ADDR_W-1:0] instr_reg,
    input  logic [DATA_W-1:0]     instr_imm,
    output logic [1:0]            alu_opcode,
    output logic [DATA_W-1:0]     alu_a,
    output logic [DATA_W-1:0]     alu_b,
    input  logic [DATA_W-1:0]     alu_out,
    input  logic                  alu_carry,
    output logic                  result_valid,
    input  logic                  result_ready,
    output logic [DATA_W-1:0]     result_data,
    output logic                  flag_carry,
    output logic                  flag_zero
);

    localparam int         c_nregs    = 1 << REG_ADDR_W;
    localparam logic [2:0] c_op_and   = 3'b000;
    localparam logic [2:0] c_op_or    = 3'b001;
    localparam logic [2:0] c_op_add   = 3'b010;
    localparam logic [2:0] c_op_sub   = 3'b011;
    localparam logic [2:0] c_op_load  = 3'b100;
    localparam logic [2:0] c_op_store = 3'b101;
    localparam logic [2:0] c_op_out   = 3'b110;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_EMIT = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [DATA_W-1:0]       acc_q, acc_d;
    logic [DATA_W-1:0]       regs_q [c_nregs];
    logic [DATA_W-1:0]       regs_d [c_nregs];
    logic [2:0]              op_q, op_d;
    logic [REG_ADDR_W-1:0]   idx_q, idx_d;
    logic [DATA_W-1:0]       opnd_q, opnd_d;
    logic [1:0]              alu_opcode_q, alu_opcode_d;
    logic [DATA_W-1:0]       alu_a_q, alu_a_d;
    logic [DATA_W-1:0]       alu_b_q, alu_b_d;
    logic                    result_valid_q, result_valid_d;
    logic [DATA_W-1:0]       result_data_q, result_data_d;
    logic                    carry_q, carry_d;
    logic                    zero_q, zero_d;
    logic                    ready_q, ready_d;
    logic                    w_accept;
    logic [DATA_W-1:0]       w_opnd;

    // Next-state logic: handshake acceptance, execution and result emission
    always_comb begin
        state_d        = state_q;
        acc_d          = acc_q;
        regs_d         = regs_q;
        op_d           = op_q;
        idx_d          = idx_q;
        opnd_d         = opnd_q;
        alu_opcode_d   = alu_opcode_q;
        alu_a_d        = alu_a_q;
        alu_b_d        = alu_b_q;
        result_valid_d = result_valid_q;
        result_data_d  = result_data_q;
        carry_d        = carry_q;
        zero_d         = zero_q;
        ready_d        = ready_q;
        w_accept       = (state_q == S_IDLE) && ready_q && instr_valid;
        w_opnd         = instr_src ? regs_q[instr_reg] : instr_imm;

        case (state_q)
            S_IDLE: begin
                if (w_accept) begin
                    op_d    = instr_op;
                    idx_d   = instr_reg;
                    opnd_d  = w_opnd;
                    ready_d = 1'b0;
                    if (instr_op == c_op_out) begin
                        state_d        = S_EMIT;
                        result_valid_d = 1'b1;
                        result_data_d  = acc_q;
                    end else begin
                        // ALU operands are registered here so they are clean for the whole EXEC cycle
                        state_d      = S_EXEC;
                        alu_opcode_d = instr_op[1:0];
                        alu_a_d      = acc_q;
                        alu_b_d      = w_opnd;
                    end
                end else begin
                    // Also raises ready on the first cycle after reset release
                    ready_d = 1'b1;
                end
            end
            S_EXEC: begin
                state_d = S_IDLE;
                ready_d = 1'b1;
                case (op_q)
                    c_op_and, c_op_or: begin
                        acc_d  = alu_out;
                        zero_d = (alu_out == '0);
                    end
                    c_op_add, c_op_sub: begin
                        acc_d   = alu_out;
                        zero_d  = (alu_out == '0);
                        carry_d = alu_carry;
                    end
                    c_op_load: begin
                        acc_d  = opnd_q;
                        zero_d = (opnd_q == '0);
                    end
                    c_op_store: begin
                        regs_d[idx_q] = acc_q;
                    end
                    default: begin
                        // NOP leaves all architectural state untouched
                    end
                endcase
            end
            S_EMIT: begin
                if (result_ready) begin
                    state_d        = S_IDLE;
                    result_valid_d = 1'b0;
                    ready_d        = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                ready_d = 1'b0;
            end
        endcase
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            acc_q          <= '0;
            for (int i = 0; i < c_nregs; i++) begin
                regs_q[i] <= '0;
            end
            op_q           <= '0;
            idx_q          <= '0;
            opnd_q         <= '0;
            alu_opcode_q   <= '0;
            alu_a_q        <= '0;
            alu_b_q        <= '0;
            result_valid_q <= 1'b0;
            result_data_q  <= '0;
            carry_q        <= 1'b0;
            zero_q         <= 1'b0;
            ready_q        <= 1'b0;
        end else begin
            state_q        <= state_d;
            acc_q          <= acc_d;
            regs_q         <= regs_d;
            op_q           <= op_d;
            idx_q          <= idx_d;
            opnd_q         <= opnd_d;
            alu_opcode_q   <= alu_opcode_d;
            alu_a_q        <= alu_a_d;
            alu_b_q        <= alu_b_d;
            result_valid_q <= result_valid_d;
            result_data_q  <= result_data_d;
            carry_q        <= carry_d;
            zero_q         <= zero_d;
            ready_q        <= ready_d;
        end
    end

    // Ready is forced low as soon as reset is asserted, without waiting for an edge
    assign instr_ready  = ready_q & rst_n;
    assign alu_opcode   = alu_opcode_q;
    assign alu_a        = alu_a_q;
    assign alu_b        = alu_b_q;
    assign result_valid = result_valid_q;
    assign result_data  = result_data_q;
    assign flag_carry   = carry_q;
    assign flag_zero    = zero_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_sequencer
//  Description : Scoreboard bench for alu_sequencer with a behavioural ALU and
//                an arithmetic reference model of the accumulator machine.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_sequencer;

    localparam logic [2:0] c_and = 3'b000, c_or = 3'b001, c_add = 3'b010, c_sub = 3'b011;
    localparam logic [2:0] c_load = 3'b100, c_store = 3'b101, c_out = 3'b110, c_nop = 3'b111;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       instr_valid = 1'b0;
    logic       instr_ready;
    logic [2:0] instr_op = 3'b111;
    logic       instr_src = 1'b0;
    logic [1:0] instr_reg = 2'd0;
    logic [7:0] instr_imm = 8'd0;
    logic [1:0] alu_opcode;
    logic [7:0] alu_a, alu_b, alu_out;
    logic       alu_carry;
    logic       result_valid;
    logic       result_ready = 1'b0;
    logic [7:0] result_data;
    logic       flag_carry, flag_zero;

    int checks = 0;
    int failures = 0;
    int ready_mode = 1;   // 0 = hold low, 1 = hold high, 2 = random

    typedef struct packed {
        logic [7:0] d;
        logic       c;
        logic       z;
    } exp_t;
    exp_t sb[$];

    // Reference model state
    logic [7:0] acc_m;
    logic [7:0] regs_m [4];
    logic       c_m, z_m;

    alu_sequencer #(.DATA_W(8), .REG_ADDR_W(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr_op(instr_op), .instr_src(instr_src), .instr_reg(instr_reg), .instr_imm(instr_imm),
        .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b),
        .alu_out(alu_out), .alu_carry(alu_carry),
        .result_valid(result_valid), .result_ready(result_ready), .result_data(result_data),
        .flag_carry(flag_carry), .flag_zero(flag_zero)
    );

    always #5 clk = ~clk;

    // Downstream combinational ALU
    always_comb begin
        alu_out   = 8'd0;
        alu_carry = 1'b0;
        case (alu_opcode)
            2'b00: alu_out = alu_a & alu_b;
            2'b01: alu_out = alu_a | alu_b;
            2'b10: {alu_carry, alu_out} = {1'b0, alu_a} + {1'b0, alu_b};
            default: {alu_carry, alu_out} = {1'b0, alu_a} + {1'b0, ~alu_b} + 9'd1;
        endcase
    end

    // Downstream ready driver
    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0: result_ready = 1'b0;
            1: result_ready = 1'b1;
            default: result_ready = ($urandom_range(0, 3) != 0);
        endcase
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic model_clear();
        acc_m = 8'd0;
        c_m = 1'b0;
        z_m = 1'b0;
        for (int i = 0; i < 4; i++) regs_m[i] = 8'd0;
    endtask

    // Monitor: pops expected results on each handshake and checks hold under stall
    initial begin
        logic       stall_prev = 1'b0;
        logic [7:0] held = 8'd0;
        exp_t       e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (stall_prev) begin
                    chk("stall_valid_held", {31'd0, result_valid}, 32'd1);
                    chk("stall_data_held", {24'd0, result_data}, {24'd0, held});
                end
                if (result_valid && result_ready) begin
                    if (sb.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_result actual=%0h required=none", result_data);
                    end else begin
                        e = sb.pop_front();
                        chk("result_data", {24'd0, result_data}, {24'd0, e.d});
                        chk("result_carry", {31'd0, flag_carry}, {31'd0, e.c});
                        chk("result_zero", {31'd0, flag_zero}, {31'd0, e.z});
                    end
                end
                stall_prev = result_valid && !result_ready;
                held = result_data;
            end else begin
                stall_prev = 1'b0;
            end
        end
    end

    // Issue one instruction; optionally assert reset during its EXEC cycle
    task automatic issue(input logic [2:0] op, input logic src, input logic [1:0] r,
                         input logic [7:0] imm, input bit abort = 0);
        int         n = 0;
        logic [7:0] o, exp_a, nacc;
        logic [8:0] s;
        logic       nc, nz;
        @(negedge clk);
        chk("flag_carry_idle", {31'd0, flag_carry}, {31'd0, c_m});
        chk("flag_zero_idle", {31'd0, flag_zero}, {31'd0, z_m});
        while (!instr_ready) begin
            n++;
            if (n > 200) begin
                checks++;
                failures++;
                $display("FAIL instr_ready_timeout actual=0 required=1");
                return;
            end
            @(negedge clk);
        end
        instr_valid = 1'b1;
        instr_op    = op;
        instr_src   = src;
        instr_reg   = r;
        instr_imm   = imm;
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        instr_op    = 3'($urandom);
        instr_src   = 1'($urandom);
        instr_reg   = 2'($urandom);
        instr_imm   = 8'($urandom);
        o = src ? regs_m[r] : imm;
        if (op == c_out) begin
            sb.push_back('{d: acc_m, c: c_m, z: z_m});
            return;
        end
        if (abort) begin
            rst_n = 1'b0;
            return;
        end
        exp_a = acc_m;
        nacc = acc_m;
        nc = c_m;
        nz = z_m;
        case (op)
            c_and:  begin nacc = acc_m & o; nz = (nacc == 0); end
            c_or:   begin nacc = acc_m | o; nz = (nacc == 0); end
            c_add:  begin s = acc_m + o; nacc = s[7:0]; nc = s[8]; nz = (nacc == 0); end
            c_sub:  begin nacc = acc_m - o; nc = (acc_m >= o); nz = (nacc == 0); end
            c_load: begin nacc = o; nz = (o == 0); end
            c_store: regs_m[r] = acc_m;
            default: ;
        endcase
        @(negedge clk);
        chk("exec_alu_opcode", {30'd0, alu_opcode}, {30'd0, op[1:0]});
        chk("exec_alu_a", {24'd0, alu_a}, {24'd0, exp_a});
        chk("exec_alu_b", {24'd0, alu_b}, {24'd0, o});
        chk("exec_instr_ready", {31'd0, instr_ready}, 32'd0);
        acc_m = nacc;
        c_m = nc;
        z_m = nz;
    endtask

    // Reset for n edges with instr_valid held high, then release
    task automatic do_reset(input int n);
        rst_n = 1'b0;
        instr_valid = 1'b1;
        sb.delete();
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            @(negedge clk);
            chk("rst_instr_ready", {31'd0, instr_ready}, 32'd0);
            chk("rst_result_valid", {31'd0, result_valid}, 32'd0);
            chk("rst_flags", {30'd0, flag_carry, flag_zero}, 32'd0);
            chk("rst_alu_drive", {14'd0, alu_opcode, alu_a, alu_b}, 32'd0);
        end
        model_clear();
        rst_n = 1'b1;
        instr_valid = 1'b0;
        @(negedge clk);
        chk("post_rst_instr_ready", {31'd0, instr_ready}, 32'd1);
    endtask

    initial begin
        int n;
        model_clear();
        ready_mode = 1;

        // Reset and emit of cleared accumulator
        do_reset(2);
        issue(c_out, 0, 0, 8'h00);

        // Arithmetic and OUT
        issue(c_load, 0, 0, 8'hF0);
        issue(c_add, 0, 0, 8'h20);
        issue(c_out, 0, 0, 8'h00);

        // Register path and borrow
        issue(c_load, 0, 0, 8'h03);
        issue(c_store, 0, 2, 8'h00);
        issue(c_load, 0, 0, 8'h05);
        issue(c_sub, 1, 2, 8'h00);
        issue(c_out, 0, 0, 8'h00);
        issue(c_load, 0, 0, 8'h03);
        issue(c_sub, 0, 0, 8'h05);
        issue(c_out, 0, 0, 8'h00);

        // Logic ops and zero flag
        issue(c_load, 0, 0, 8'hAA);
        issue(c_and, 0, 0, 8'h55);
        issue(c_out, 0, 0, 8'h00);
        issue(c_or, 0, 0, 8'h0F);
        issue(c_out, 0, 0, 8'h00);

        // Backpressure
        ready_mode = 0;
        issue(c_out, 0, 0, 8'h00);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_valid", {31'd0, result_valid}, 32'd1);
            chk("bp_data", {24'd0, result_data}, {24'd0, acc_m});
            chk("bp_instr_ready", {31'd0, instr_ready}, 32'd0);
        end
        ready_mode = 1;
        @(negedge clk);
        @(negedge clk);
        chk("bp_valid_dropped", {31'd0, result_valid}, 32'd0);
        chk("bp_back_to_idle", {31'd0, instr_ready}, 32'd1);

        // Reset during EXEC of ADD
        issue(c_load, 0, 0, 8'h40);
        issue(c_add, 0, 0, 8'h11, 1);
        do_reset(1);
        issue(c_out, 0, 0, 8'h00);

        // Reset during EMIT, register file must be cleared too
        issue(c_load, 0, 0, 8'h77);
        issue(c_store, 0, 1, 8'h00);
        ready_mode = 0;
        issue(c_out, 0, 0, 8'h00);
        @(negedge clk);
        chk("emit_before_reset", {31'd0, result_valid}, 32'd1);
        @(posedge clk);
        #1;
        do_reset(1);
        ready_mode = 1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("no_stale_result", {31'd0, result_valid}, 32'd0);
        end
        issue(c_load, 1, 1, 8'hFF);
        issue(c_out, 0, 0, 8'h00);

        // Randomized instruction stream with random backpressure
        ready_mode = 2;
        for (int i = 0; i < 200; i++) begin
            issue(3'($urandom_range(0, 7)), 1'($urandom), 2'($urandom), 8'($urandom));
        end
        issue(c_out, 0, 0, 8'h00);

        ready_mode = 1;
        n = 0;
        while (sb.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("scoreboard_drained", sb.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
